rv32i_hazard_ctrl: RTL
======================

# rv32i_hazard_ctrl

Pipeline hazard and redirect controller for the 5-stage rv32i core. It sits beside the decoder/ALU boundary and watches the registered source addresses leaving the decoder against destinations in flight in the memory-access and writeback stages. It drives the shared `STALL_WIDTH` stall vector, per-stage flushes and operand-forward selects. It sequences load-use bubbles, data-memory wait stalls and multi-cycle flush windows after a PC redirect or trap.

## Interface
- FLUSH_CYCLES, 2: number of cycles fetch/decoder flush is held after a redirect; legal range 1..7.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- i_dec_ce  in  1  decoder output valid; the instruction is entering the ALU stage.
- i_dec_rs1_addr / i_dec_rs2_addr  in  5  registered source addresses from the decoder.
- i_dec_use_rs1 / i_dec_use_rs2  in  1  the instruction actually reads rs1 / rs2.
- i_alu_ce, i_alu_wr_rd, i_alu_is_load  in  1  memory-stage instruction: valid, writes rd, is a load.
- i_alu_rd_addr  in  5  memory-stage rd.
- i_mem_ce, i_mem_wr_rd  in  1  writeback-stage instruction: valid, writes rd.
- i_mem_rd_addr  in  5  writeback-stage rd.
- i_dmem_req, i_dmem_ack  in  1  data-memory request outstanding / completed.
- i_change_pc  in  1  branch or jump taken, from the ALU stage.
- i_trap  in  1  trap or mret redirect, from writeback.
- o_stall  out  `STALL_WIDTH`  per-stage stall, indexed by `FETCH`/`DECODER`/`ALU`/`MEMORYACCESS`/`WRITEBACK`.
- o_flush_fetch, o_flush_dec, o_flush_alu, o_flush_mem  out  1  per-stage flush.
- o_fwd_rs1 / o_fwd_rs2  out  2  forward source: 00 regfile, 01 memory-stage result, 10 writeback result.
- o_state  out  2  current FSM state, for debug.

## Operation
- FSM states: RUN=0, DMEM_WAIT=1, REDIRECT=2. The load-use bubble is a combinational single-cycle condition, not a state.
- Priority, highest first: i_trap, i_change_pc, dmem wait, load-use, RAW (only when forwarding is disabled).
- Address 0 never matches as a hazard or a forward source.
- Trap:
  - o_flush_fetch, o_flush_dec, o_flush_alu and o_flush_mem are all asserted the same cycle.
  - The FSM enters REDIRECT with cnt=FLUSH_CYCLES-1.
- Change_pc (no trap):
  - o_flush_fetch and o_flush_dec are asserted the same cycle.
  - The FSM enters REDIRECT with cnt=FLUSH_CYCLES-1.
- REDIRECT:
  - o_flush_fetch and o_flush_dec stay high while cnt!=0; cnt decrements each cycle.
  - At cnt==0, flushes drop and the FSM returns to RUN.
  - A new change_pc or trap in REDIRECT reloads cnt, and adds the ALU/memory flushes if it is a trap.
  - FLUSH_CYCLES=1 means the FSM returns to RUN on the next cycle.
- Dmem wait, when i_dmem_req && !i_dmem_ack:
  - Assert o_stall bits FETCH, DECODER, ALU and MEMORYACCESS; the FSM enters or stays in DMEM_WAIT.
  - The FSM returns to RUN the cycle after the ack. The stall drops in the same cycle the ack is seen.
- Load-use: i_dec_ce && i_alu_ce && i_alu_is_load && i_alu_wr_rd && rd!=0 && a used rs matches i_alu_rd_addr.
  - Assert o_stall bits FETCH, DECODER and ALU for one cycle only; the memory stage receives a bubble.
  - On the next cycle the load is in writeback and its value is forwarded with select 10.
- Forward select, per rs:
  - 01 if it matches a valid, non-load memory-stage rd.
  - Otherwise 10 if it matches a valid writeback rd.
  - Otherwise 00. The memory stage wins when both match.
- o_stall[WRITEBACK] is always 0.
- A trap or change_pc masks all stalls in the same cycle.

## Timing
- o_stall, o_flush_* and o_fwd_* are combinational from inputs and current state: zero-cycle latency.
- FSM and cnt are registered.
- Reset: state=RUN, cnt=0. While i_rst_n=0, every output is 0 (o_state=0).
- Reset asserted mid-REDIRECT or mid-DMEM_WAIT aborts immediately; there is no residual flush or stall after release.
- Redirect flush window: cycles N .. N+FLUSH_CYCLES-1.

## Configuration
- RV32I_FORWARDING_EN defined:
  - Forwarding is as described.
  - Only load-use and dmem wait stall.
- RV32I_FORWARDING_EN undefined:
  - o_fwd_rs1 and o_fwd_rs2 are tied to 00.
  - Any used rs matching a valid, writing memory-stage or writeback rd asserts o_stall FETCH/DECODER/ALU.
  - The stall continues until no match remains, up to 2 cycles.

## Test plan
- Back-to-back dependency: add x5 in memory stage, next instruction uses rs1=x5. With forwarding: fwd_rs1=01, no stall. Without: 2 stall cycles, fwd=00.
- Load-use: lw x7 in memory stage, rs2=x7 → o_stall FETCH|DECODER|ALU for exactly 1 cycle, then fwd_rs2=10.
- Dmem wait: req=1, ack low for 3 cycles → stall bits 0..3 high for 3 cycles, o_state=1; they drop on the ack cycle and o_state=0 the next cycle.
- Redirect: change_pc pulse with FLUSH_CYCLES=2 → fetch/dec flush high for 2 cycles. A second change_pc in cycle 2 extends the window to cycle 3.
- Trap during a load-use plus dmem wait → all four flushes high, stall=0 that cycle, state=REDIRECT.
- x0 and reset: rd=x0 matching rs1=x0 → no stall, fwd=00. Reset pulse in REDIRECT → all outputs 0, state RUN after release.

Source files
------------

// File: rtl/rv32i_hazard_ctrl.sv
// rv32i_hazard_ctrl: load-use / dmem-wait stalls, redirect flush windows and operand forwarding.
// Build option RV32I_FORWARDING_EN: enable forwarding; when undefined, RAW hazards stall instead.
`ifndef STALL_WIDTH
`define STALL_WIDTH 5
`endif
`ifndef FETCH
`define FETCH 0
`endif
`ifndef DECODER
`define DECODER 1
`endif
`ifndef ALU
`define ALU 2
`endif
`ifndef MEMORYACCESS
`define MEMORYACCESS 3
`endif
`ifndef WRITEBACK
`define WRITEBACK 4
`endif

module rv32i_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_dec_ce,
    input  logic [4:0]              i_dec_rs1_addr,
    input  logic [4:0]              i_dec_rs2_addr,
    input  logic                    i_dec_use_rs1,
    input  logic                    i_dec_use_rs2,
    input  logic                    i_alu_ce,
    input  logic                    i_alu_wr_rd,
    input  logic                    i_alu_is_load,
    input  logic [4:0]              i_alu_rd_addr,
    input  logic                    i_mem_ce,
    input  logic                    i_mem_wr_rd,
    input  logic [4:0]              i_mem_rd_addr,
    input  logic                    i_dmem_req,
    input  logic                    i_dmem_ack,
    input  logic                    i_change_pc,
    input  logic                    i_trap,
    output logic [`STALL_WIDTH-1:0] o_stall,
    output logic                    o_flush_fetch,
    output logic                    o_flush_dec,
    output logic                    o_flush_alu,
    output logic                    o_flush_mem,
    output logic [1:0]              o_fwd_rs1,
    output logic [1:0]              o_fwd_rs2,
    output logic [1:0]              o_state
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        DMEM_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    localparam logic [2:0] RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t                  state;
    logic [2:0]              cnt;
    logic                    redirect;
    logic                    dmem_wait;
    logic                    load_use;
    logic                    raw;
    logic                    window;
    logic                    alu_fwd_ok;
    logic                    mem_fwd_ok;
    logic [`STALL_WIDTH-1:0] stall;
    logic [1:0]              fwd_rs1;
    logic [1:0]              fwd_rs2;

    // x0 is hardwired zero, so it never participates in a match.
    function automatic logic hit(input logic [4:0] rs, input logic [4:0] rd, input logic valid);
        return valid && (rs != '0) && (rs == rd);
    endfunction

    assign redirect  = i_trap || i_change_pc;
    assign dmem_wait = i_dmem_req && !i_dmem_ack;
    assign window    = (state == REDIRECT) && (cnt != '0);

    assign load_use = i_dec_ce && i_alu_ce && i_alu_is_load && i_alu_wr_rd &&
                      ((i_dec_use_rs1 && hit(i_dec_rs1_addr, i_alu_rd_addr, 1'b1)) ||
                       (i_dec_use_rs2 && hit(i_dec_rs2_addr, i_alu_rd_addr, 1'b1)));

`ifdef RV32I_FORWARDING_EN
    assign alu_fwd_ok = i_alu_ce && i_alu_wr_rd && !i_alu_is_load;
    assign mem_fwd_ok = i_mem_ce && i_mem_wr_rd;
    assign raw        = 1'b0;

    always_comb begin
        fwd_rs1 = 2'b00;
        fwd_rs2 = 2'b00;
        if (hit(i_dec_rs1_addr, i_alu_rd_addr, alu_fwd_ok))
            fwd_rs1 = 2'b01;
        else if (hit(i_dec_rs1_addr, i_mem_rd_addr, mem_fwd_ok))
            fwd_rs1 = 2'b10;
        if (hit(i_dec_rs2_addr, i_alu_rd_addr, alu_fwd_ok))
            fwd_rs2 = 2'b01;
        else if (hit(i_dec_rs2_addr, i_mem_rd_addr, mem_fwd_ok))
            fwd_rs2 = 2'b10;
    end
`else
    // Without forwarding, loads and ALU results alike hold decode until they retire.
    assign alu_fwd_ok = i_alu_ce && i_alu_wr_rd;
    assign mem_fwd_ok = i_mem_ce && i_mem_wr_rd;
    assign raw = i_dec_ce &&
                 ((i_dec_use_rs1 && (hit(i_dec_rs1_addr, i_alu_rd_addr, alu_fwd_ok) ||
                                     hit(i_dec_rs1_addr, i_mem_rd_addr, mem_fwd_ok))) ||
                  (i_dec_use_rs2 && (hit(i_dec_rs2_addr, i_alu_rd_addr, alu_fwd_ok) ||
                                     hit(i_dec_rs2_addr, i_mem_rd_addr, mem_fwd_ok))));
    assign fwd_rs1 = 2'b00;
    assign fwd_rs2 = 2'b00;
`endif

    always_comb begin
        stall = '0;
        if (!redirect) begin
            if (dmem_wait) begin
                stall[`FETCH]        = 1'b1;
                stall[`DECODER]      = 1'b1;
                stall[`ALU]          = 1'b1;
                stall[`MEMORYACCESS] = 1'b1;
            end else if (load_use || raw) begin
                stall[`FETCH]   = 1'b1;
                stall[`DECODER] = 1'b1;
                stall[`ALU]     = 1'b1;
            end
        end
    end

    // An open flush window takes precedence over a dmem wait; the wait is picked up at cnt==0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (redirect) begin
            state <= REDIRECT;
            cnt   <= RELOAD;
        end else if (window) begin
            cnt <= cnt - 3'd1;
        end else if (dmem_wait) begin
            state <= DMEM_WAIT;
        end else begin
            state <= RUN;
        end
    end

    assign o_stall       = i_rst_n ? stall : '0;
    assign o_flush_fetch = i_rst_n && (redirect || window);
    assign o_flush_dec   = i_rst_n && (redirect || window);
    assign o_flush_alu   = i_rst_n && i_trap;
    assign o_flush_mem   = i_rst_n && i_trap;
    assign o_fwd_rs1     = i_rst_n ? fwd_rs1 : 2'b00;
    assign o_fwd_rs2     = i_rst_n ? fwd_rs2 : 2'b00;
    assign o_state       = i_rst_n ? state : RUN;

endmodule
